key_filter: RTL and testbench
=============================

# key_filter

Debounces the raw active-low push-button input and turns it into clean, single-cycle press and release events plus a stable level. It sits between the board key pin and the LED/control logic. It is the input-side counterpart of the LED output path: downstream logic consumes `key_flag` and `key_level` instead of the raw pin.

## Interface
- `CNT_MAX`, default 999_999: debounce window minus one, in clock cycles. The default gives 20 ms at 50 MHz. Width is 20 bits; the legal range is 1..1_048_575.
- `LONG_MAX`, default 49_999_999: long-press threshold minus one, in cycles. The default gives 1 s at 50 MHz. Width is 26 bits; it must satisfy `LONG_MAX` > `CNT_MAX`.
- One clock; reset is synchronous and active-high. Ports:
- `sys_clk`  input  1  system clock; all logic is on the rising edge.
- `sys_rst`  input  1  synchronous, active-high reset.
- `key_in`  input  1  raw key pin, asynchronous and bouncing; 0 = pressed.
- `key_flag`  output  1  one-cycle pulse on each debounced press.
- `key_rel_flag`  output  1  one-cycle pulse on each debounced release.
- `key_level`  output  1  debounced state; 1 = held.
- `key_long`  output  1  one-cycle pulse once per press when the hold reaches `LONG_MAX` (see Configuration).

## Operation
- **Synchronizer:** a two-flop chain on `key_in` produces `key_s`. Both flops reset to 1 (released).
- **State machine** (one-hot or binary, designer's choice). Reset state is IDLE.
  - IDLE: if `key_s`=0, go to PRESS_FILT and set cnt=0.
  - PRESS_FILT:
    - if `key_s`=1, go to IDLE and clear cnt (bounce rejected, no output);
    - else if cnt==`CNT_MAX`, go to HELD, pulse `key_flag`, set `key_level`=1;
    - else cnt+1.
  - HELD: if `key_s`=1, go to REL_FILT and set cnt=0.
  - REL_FILT:
    - if `key_s`=0, go to HELD and clear cnt (release bounce rejected; `key_level` stays 1);
    - else if cnt==`CNT_MAX`, go to IDLE, pulse `key_rel_flag`, set `key_level`=0;
    - else cnt+1.
- **Counter:** a single 20-bit debounce counter shared by both filter states. It never wraps, because it is cleared at `CNT_MAX`.
- **Event pairing:** `key_flag` and `key_rel_flag` always alternate, press first after reset, and can never be high in the same cycle.
- **Reset mid-operation:** `sys_rst`=1 in any state forces IDLE, cnt=0, all outputs to 0 and the synchronizer to 1 on the next edge. No release pulse is generated for a key held across reset. A key still held after reset is re-detected as a new press once it has been stable for the full window.

## Timing
- Reset values: `key_flag`=0, `key_rel_flag`=0, `key_level`=0, `key_long`=0.
- All outputs are registered; there is no combinational path from `key_in`.
- **Press latency:** with `key_in` low and stable before edge E0, `key_flag` and `key_level` go high after edge E0+`CNT_MAX`+3. `key_flag` is high for exactly one cycle.
- **Release latency:** symmetric. With `key_in` high and stable before edge E0 while in HELD, `key_rel_flag` goes high and `key_level` goes low after edge E0+`CNT_MAX`+3.
- **Minimum pulse:** any low (or high) glitch on `key_s` shorter than `CNT_MAX`+2 cycles produces no event.
- **Back-to-back events:** a press followed by a release needs at least 2·(`CNT_MAX`+2) cycles between the first `key_in` edge and `key_rel_flag`.

## Configuration
- Macro `KEY_LONG_PRESS_EN`.
- **Defined:** a 26-bit hold counter runs only in HELD and REL_FILT. It clears on entry to HELD from PRESS_FILT and saturates at `LONG_MAX`. On the cycle it first equals `LONG_MAX`, `key_long` pulses for one cycle; it pulses at most once per press. A release bounce (REL_FILT back to HELD) does not clear the hold counter.
- **Not defined:** the hold counter is not instantiated and `key_long` is tied to 0. All other behaviour is identical.

## Test plan
All scenarios use `CNT_MAX`=9 and `LONG_MAX`=49.
- Reset for 3 cycles, `key_in`=1 throughout -> all outputs 0; the state stays IDLE for 100 cycles.
- Clean press: `key_in` goes to 0 before edge E0 and is held -> `key_flag`=1 only after edge E0+12; `key_level`=1 from then on.
- Bouncy press: toggles of 0 for 5 cycles and 1 for 3 cycles, repeated 4 times, then a stable 0 -> exactly one `key_flag`, 12 edges after the final falling edge; no pulse during the bouncing.
- Clean release after the press -> `key_rel_flag` pulses 12 edges after `key_in` rises; `key_level`=0. A 6-cycle high glitch while held -> no `key_rel_flag`.
- Long press with `KEY_LONG_PRESS_EN` defined and `key_in` held low for 200 cycles -> `key_long` pulses once, 50 cycles after `key_flag`. With the macro undefined -> `key_long` stays 0.
- `sys_rst` asserted for 1 cycle while in HELD -> next edge shows all outputs 0. The held key then produces a new `key_flag` after 12 more edges. No `key_rel_flag` appears at any point.

Source files
------------

// File: rtl/key_filter.sv
// Debounces an active-low, bouncing push-button into clean press/release pulses and a stable level.
// Optional long-press pulse is built only when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied to 0.
module key_filter #(
    parameter logic [19:0] CNT_MAX  = 20'd999_999,
    parameter logic [25:0] LONG_MAX = 26'd49_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_rel_flag,
    output logic key_level,
    output logic key_long
);

    if (LONG_MAX <= {6'd0, CNT_MAX} || CNT_MAX == 20'd0) begin : g_param_check
        $error("key_filter: need CNT_MAX >= 1 and LONG_MAX > CNT_MAX");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        HELD       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [19:0] cnt;
    logic [19:0] cnt_nxt;
    logic        key_meta;
    logic        key_s;
    logic        flag_nxt;
    logic        rel_nxt;
    logic        level_nxt;

    // Two-flop synchronizer; idles at 1 so reset looks like a released key.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_meta <= 1'b1;
            key_s    <= 1'b1;
        end else begin
            key_meta <= key_in;
            key_s    <= key_meta;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state        <= IDLE;
            cnt          <= 20'd0;
            key_flag     <= 1'b0;
            key_rel_flag <= 1'b0;
            key_level    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            key_flag     <= flag_nxt;
            key_rel_flag <= rel_nxt;
            key_level    <= level_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        flag_nxt  = 1'b0;
        rel_nxt   = 1'b0;
        level_nxt = key_level;
        case (state)
            IDLE: begin
                if (!key_s) begin
                    state_nxt = PRESS_FILT;
                    cnt_nxt   = 20'd0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 20'd0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = HELD;
                    cnt_nxt   = 20'd0;
                    flag_nxt  = 1'b1;
                    level_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            HELD: begin
                if (key_s) begin
                    state_nxt = REL_FILT;
                    cnt_nxt   = 20'd0;
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    state_nxt = HELD;
                    cnt_nxt   = 20'd0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 20'd0;
                    rel_nxt   = 1'b1;
                    level_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt + 20'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 20'd0;
            end
        endcase
    end

`ifdef KEY_LONG_PRESS_EN
    logic [25:0] hold_cnt;
    logic        long_fired;

    // Hold time survives release bounces; only a fresh press restarts it.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_cnt   <= 26'd0;
            long_fired <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_long <= 1'b0;
            if (state == PRESS_FILT && state_nxt == HELD) begin
                hold_cnt   <= 26'd0;
                long_fired <= 1'b0;
            end else if (state == HELD || state == REL_FILT) begin
                if (hold_cnt != LONG_MAX) begin
                    hold_cnt <= hold_cnt + 26'd1;
                end
                if (hold_cnt == LONG_MAX && !long_fired) begin
                    key_long   <= 1'b1;
                    long_fired <= 1'b1;
                end
            end
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=9, LONG_MAX=49 (press latency 12 edges after E0).
module tb_key_filter;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic key_in  = 1'b1;
    logic key_flag;
    logic key_rel_flag;
    logic key_level;
    logic key_long;

    int checks = 0;
    int errors = 0;
    int n_flag;
    int n_rel;
    int n_long;
    int n_any;

    key_filter #(.CNT_MAX(20'd9), .LONG_MAX(26'd49)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .key_in       (key_in),
        .key_flag     (key_flag),
        .key_rel_flag (key_rel_flag),
        .key_level    (key_level),
        .key_long     (key_long)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit before sampling/driving.
    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    // Advance n edges, counting pulses seen after each edge.
    task automatic run(input int n);
        n_flag = 0;
        n_rel  = 0;
        n_long = 0;
        n_any  = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            n_flag += int'(key_flag);
            n_rel  += int'(key_rel_flag);
            n_long += int'(key_long);
            n_any  += int'(key_flag | key_rel_flag | key_level | key_long);
        end
    endtask

    initial begin
        // Reset held for 3 edges with the key released.
        sys_rst = 1'b1;
        key_in  = 1'b1;
        run(3);
        check("rst_flag", key_flag, 0);
        check("rst_rel", key_rel_flag, 0);
        check("rst_level", key_level, 0);
        check("rst_long", key_long, 0);
        sys_rst = 1'b0;
        run(100);
        check("idle_quiet", n_any, 0);

        // Clean press: E0 is the first edge after key_in falls.
        key_in = 1'b0;
        run(12);
        check("press_early", n_flag, 0);
        tick();
        check("press_flag", key_flag, 1);
        check("press_level", key_level, 1);
        tick();
        check("press_flag_1cyc", key_flag, 0);
        check("press_level_hold", key_level, 1);
        // Key held ~200 cycles total; key_long due 50 edges after key_flag.
        run(48);
`ifdef KEY_LONG_PRESS_EN
        check("long_early", n_long, 0);
        tick();
        check("long_pulse", key_long, 1);
        tick();
        check("long_1cyc", key_long, 0);
        run(148);
        check("long_once", n_long, 0);
`else
        run(150);
        check("long_off", n_long, 0);
        check("long_off_now", key_long, 0);
`endif
        check("held_no_rel", n_rel, 0);
        check("held_level", key_level, 1);

        // Clean release.
        key_in = 1'b1;
        run(12);
        check("rel_early", n_rel, 0);
        check("rel_level_early", key_level, 1);
        tick();
        check("rel_flag", key_rel_flag, 1);
        check("rel_level", key_level, 0);
        tick();
        check("rel_flag_1cyc", key_rel_flag, 0);
        run(20);

        // Bouncy press: 4x (5 low, 3 high), then stable low.
        n_any = 0;
        for (int r = 0; r < 4; r++) begin
            key_in = 1'b0;
            run(5);
            check("bounce_lo_quiet", n_flag + n_rel, 0);
            key_in = 1'b1;
            run(3);
            check("bounce_hi_quiet", n_flag + n_rel, 0);
        end
        key_in = 1'b0;
        run(12);
        check("bounce_early", n_flag, 0);
        tick();
        check("bounce_flag", key_flag, 1);
        tick();
        check("bounce_flag_1cyc", key_flag, 0);

        // 6-cycle high glitch while held must not release.
        key_in = 1'b1;
        run(6);
        key_in = 1'b0;
        n_rel = 0;
        run(30);
        check("glitch_no_rel", n_rel, 0);
        check("glitch_level", key_level, 1);

        // One-cycle reset while held; key stays pressed.
        sys_rst = 1'b1;
        tick();
        check("midrst_flag", key_flag, 0);
        check("midrst_rel", key_rel_flag, 0);
        check("midrst_level", key_level, 0);
        check("midrst_long", key_long, 0);
        sys_rst = 1'b0;
        run(12);
        check("redetect_early", n_flag, 0);
        check("redetect_no_rel", n_rel, 0);
        tick();
        check("redetect_flag", key_flag, 1);
        check("redetect_level", key_level, 1);
        check("redetect_no_rel2", key_rel_flag, 0);
        run(20);
        check("redetect_quiet", n_flag + n_rel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: got still running, expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
